// File: rtl/monitor_event_sched.sv
// Shares one monitor output channel among NUM_REQ collectors: one-deep buffer per
// collector, round-robin pick, minimum issue gap, valid/ready output, saturating drops.
module monitor_event_sched #(
   parameter int  NUM_REQ = 4,
   parameter int  DATA_W  = 32,
   parameter int  MIN_GAP = 2,
   parameter int  CNT_W   = 16,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      mon_valid,
   input  logic                      mon_ready,
   output logic [DATA_W-1:0]         mon_data,
   output logic [PTR_W-1:0]          mon_src,
   output logic [NUM_REQ-1:0]        pending,
   output logic [CNT_W-1:0]          drop_count
);

   localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam int SUM_W = CNT_W + $clog2(NUM_REQ + 1);

   logic [NUM_REQ-1:0][DATA_W-1:0] slot_q;
   logic [NUM_REQ-1:0]             pend_q, pend_d, grant, drop;
   logic [PTR_W-1:0]               rr_q, rr_d, gidx;
   logic [GAP_W-1:0]               gap_q, gap_d;
   logic                           vld_q, vld_d;
   logic [DATA_W-1:0]              data_q, data_d;
   logic [PTR_W-1:0]               src_q, src_d;
   logic [CNT_W-1:0]               drop_q, drop_d;
   logic                           out_free, load, found;
   logic [PTR_W:0]                 cand;
   logic [SUM_W-1:0]               sum;

   assign out_free = !vld_q || mon_ready;
   assign load     = enable && out_free && (gap_q == '0) && (|pend_q);

   // Search pending slots starting at rr_q, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_REQ))
            cand = cand - (PTR_W+1)'(NUM_REQ);
         if (!found && pend_q[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            gidx  = cand[PTR_W-1:0];
         end
      end
      grant = '0;
      if (load)
         grant[gidx] = 1'b1;
   end

   always_comb begin
      drop   = req_valid & pend_q & ~grant;
      pend_d = req_valid | (pend_q & ~grant);
      sum    = SUM_W'(drop_q);
      for (int i = 0; i < NUM_REQ; i++)
         sum = sum + SUM_W'(drop[i]);
      if (sum > SUM_W'({CNT_W{1'b1}}))
         drop_d = '1;
      else
         drop_d = sum[CNT_W-1:0];

      vld_d  = vld_q;
      data_d = data_q;
      src_d  = src_q;
      rr_d   = rr_q;
      gap_d  = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
      if (load) begin
         vld_d  = 1'b1;
         data_d = slot_q[gidx];
         src_d  = gidx;
         rr_d   = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
         gap_d  = GAP_W'(MIN_GAP-1);
      end else if (mon_ready) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         pend_q <= '0;
         rr_q   <= '0;
         gap_q  <= '0;
         vld_q  <= 1'b0;
         data_q <= '0;
         src_q  <= '0;
         drop_q <= '0;
      end else begin
         // A granted slot may be refilled by a strobe in the same cycle.
         for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && (!pend_q[i] || grant[i]))
               slot_q[i] <= req_data[i*DATA_W +: DATA_W];
         pend_q <= pend_d;
         rr_q   <= rr_d;
         gap_q  <= gap_d;
         vld_q  <= vld_d;
         data_q <= data_d;
         src_q  <= src_d;
         drop_q <= drop_d;
      end
   end

   assign mon_valid  = vld_q;
   assign mon_data   = data_q;
   assign mon_src    = src_q;
   assign pending    = pend_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_monitor_event_sched.sv
// Directed bench: three instances (gap 2, gap 1, gap 3 with 2-bit drop counter)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_monitor_event_sched;

   logic         clk = 1'b0;
   logic         rst, enable, mon_ready;
   logic [3:0]   req_valid;
   logic [127:0] req_data;

   logic         a_vld, b_vld, c_vld;
   logic [31:0]  a_data, b_data, c_data;
   logic [1:0]   a_src, b_src, c_src;
   logic [3:0]   a_pend, b_pend, c_pend;
   logic [15:0]  a_drop, b_drop;
   logic [1:0]   c_drop;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   monitor_event_sched #(.NUM_REQ(4), .DATA_W(32), .MIN_GAP(2), .CNT_W(16)) ua (
      .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .mon_valid(a_vld), .mon_ready(mon_ready), .mon_data(a_data), .mon_src(a_src),
      .pending(a_pend), .drop_count(a_drop));

   monitor_event_sched #(.NUM_REQ(4), .DATA_W(32), .MIN_GAP(1), .CNT_W(16)) ub (
      .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .mon_valid(b_vld), .mon_ready(mon_ready), .mon_data(b_data), .mon_src(b_src),
      .pending(b_pend), .drop_count(b_drop));

   monitor_event_sched #(.NUM_REQ(4), .DATA_W(32), .MIN_GAP(3), .CNT_W(2)) uc (
      .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .mon_valid(c_vld), .mon_ready(mon_ready), .mon_data(c_data), .mon_src(c_src),
      .pending(c_pend), .drop_count(c_drop));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [31:0] v);
      req_data[i*32 +: 32] = v;
   endtask

   initial begin
      // reset with strobes asserted, then first event latency
      rst = 1'b1; enable = 1'b1; mon_ready = 1'b1; req_valid = 4'hF;
      req_data = {4{32'hDEAD_BEEF}};
      step(); step();
      check("t1_rst_vld",  32'(a_vld),  32'd0);
      check("t1_rst_data", a_data,      32'd0);
      check("t1_rst_src",  32'(a_src),  32'd0);
      check("t1_rst_pend", 32'(a_pend), 32'd0);
      check("t1_rst_drop", 32'(a_drop), 32'd0);
      check("t1_rst_pend_c", 32'(c_pend), 32'd0);

      rst = 1'b0; req_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_data(i, 32'd10 + 32'(i));
      step();
      check("t1_e1_pend", 32'(a_pend), 32'hF);
      check("t1_e1_vld",  32'(a_vld),  32'd0);
      req_valid = 4'h0;

      // round robin back-to-back (ub) and gap of 3 (uc)
      for (int e = 2; e <= 12; e++) begin
         step();
         if (e == 2) begin
            check("t1_first_vld",  32'(a_vld), 32'd1);
            check("t1_first_src",  32'(a_src), 32'd0);
            check("t1_first_data", a_data,     32'd10);
         end
         check("t2_vld", 32'(b_vld), (e <= 5) ? 32'd1 : 32'd0);
         if (e <= 5) begin
            check("t2_src",  32'(b_src), 32'(e - 2));
            check("t2_data", b_data,     32'(10 + e - 2));
         end
         check("t3_vld", 32'(c_vld), (((e - 2) % 3 == 0) && e <= 11) ? 32'd1 : 32'd0);
         if (((e - 2) % 3 == 0) && e <= 11) begin
            check("t3_src",  32'(c_src), 32'((e - 2) / 3));
            check("t3_data", c_data,     32'(10 + (e - 2) / 3));
         end
      end
      check("t2_drop", 32'(b_drop), 32'd0);

      // backpressure: output held, second strobe on collector 2 dropped
      rst = 1'b1; step(); rst = 1'b0;
      mon_ready = 1'b0; req_valid = 4'b0101;
      set_data(0, 32'h20); set_data(2, 32'h22);
      step();
      req_valid = 4'h0;
      step();
      check("t4_load_vld",  32'(a_vld), 32'd1);
      check("t4_load_data", a_data,     32'h20);
      req_valid = 4'b0100; set_data(2, 32'h99);
      step();
      req_valid = 4'h0;
      check("t4_drop", 32'(a_drop), 32'd1);
      for (int c = 0; c < 4; c++) begin
         check("t4_hold_vld",  32'(a_vld), 32'd1);
         check("t4_hold_data", a_data,     32'h20);
         check("t4_hold_src",  32'(a_src), 32'd0);
         if (c < 3) step();
      end
      mon_ready = 1'b1;
      step();
      check("t4_next_vld",  32'(a_vld), 32'd1);
      check("t4_next_src",  32'(a_src), 32'd2);
      check("t4_next_data", a_data,     32'h22);

      // grant and refill of collector 1 in the same cycle
      rst = 1'b1; step(); rst = 1'b0;
      req_valid = 4'b0010; set_data(1, 32'h1111);
      step();
      set_data(1, 32'hBEEF);
      step();
      req_valid = 4'h0;
      check("t5_src",  32'(a_src),  32'd1);
      check("t5_data", a_data,      32'h1111);
      check("t5_pend", 32'(a_pend), 32'b0010);
      step();
      check("t5_gap_vld", 32'(a_vld), 32'd0);
      step();
      check("t5_refill_vld",  32'(a_vld),  32'd1);
      check("t5_refill_src",  32'(a_src),  32'd1);
      check("t5_refill_data", a_data,      32'hBEEF);
      check("t5_drop",        32'(a_drop), 32'd0);

      // drop saturation, then enable gating
      rst = 1'b1; step(); rst = 1'b0;
      mon_ready = 1'b0; req_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_data(i, 32'h60 + 32'(i));
      step();
      req_valid = 4'h0;
      step();
      for (int i = 0; i < 4; i++) set_data(i, 32'hFF);
      req_valid = 4'b1110;
      step();
      req_valid = 4'b0110;
      step();
      req_valid = 4'h0;
      check("t6_sat_drop",  32'(c_drop), 32'd3);
      check("t6_wide_drop", 32'(a_drop), 32'd5);
      enable = 1'b0; mon_ready = 1'b1;
      step();
      check("t6_dis_vld",  32'(c_vld),  32'd0);
      check("t6_dis_pend", 32'(c_pend), 32'b1110);
      req_valid = 4'b1000;
      step();
      req_valid = 4'h0;
      check("t6_dis_drop", 32'(a_drop), 32'd6);
      check("t6_dis_vld2", 32'(c_vld),  32'd0);
      step(); step();
      check("t6_dis_vld3",  32'(c_vld),  32'd0);
      check("t6_dis_pend3", 32'(c_pend), 32'b1110);
      enable = 1'b1;
      step();
      check("t6_en_vld",  32'(c_vld), 32'd1);
      check("t6_en_src",  32'(c_src), 32'd1);
      check("t6_en_data", c_data,     32'h61);
      check("t6_en_src_a", 32'(a_src), 32'd1);

      // reset while an event is presented
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_vld",  32'(a_vld),  32'd0);
      check("rst_mid_data", a_data,      32'd0);
      check("rst_mid_pend", 32'(a_pend), 32'd0);
      check("rst_mid_drop", 32'(a_drop), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
